uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 85 ++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter over a tdata/tvalid/tready handshake.
// Optional sticky overflow flag is built only when UART_TX_FIFO_OVF_EN is defined.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [7:0]       tdata,
    output logic             tvalid,
    input  logic             tready,
    input  logic             ovf_clr,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign tvalid = (count_q != '0);
    assign count  = count_q;
    assign tdata  = mem[rd_ptr];

    // Both decisions use pre-edge state, so a write while full is dropped even if a pop frees a slot.
    assign push = wr_en && !full;
    assign pop  = tvalid && tready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo, including a small UART serializer on the output.
// Overflow expectations follow UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 5;
    localparam int WAIT_DIV = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             wr_en = 1'b0;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [7:0]       tdata;
    logic             tvalid;
    logic             tready;
    logic             ovf_clr = 1'b0;
    logic             overflow;

    logic tready_drv = 1'b0;
    logic uart_on = 1'b0;
    logic busy = 1'b0;
    logic line = 1'b1;
    logic [9:0] frame = 10'h3ff;
    int   bitn = 0;
    int   div = 0;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q [$];

    uart_tx_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .count(count), .tdata(tdata), .tvalid(tvalid), .tready(tready),
        .ovf_clr(ovf_clr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    assign tready = uart_on ? !busy : tready_drv;

    // Transmitter model: 10-bit frame, LSB first, WAIT_DIV clocks per bit, busy for the whole frame.
    always @(posedge clk) begin
        if (uart_on) begin
            if (busy) begin
                if (div == WAIT_DIV - 1) begin
                    div <= 0;
                    if (bitn == 9) begin
                        busy <= 1'b0;
                        line <= 1'b1;
                    end else begin
                        bitn <= bitn + 1;
                        line <= frame[bitn + 1];
                    end
                end else begin
                    div <= div + 1;
                end
            end else if (tvalid) begin
                frame <= {1'b1, tdata, 1'b0};
                line  <= 1'b0;
                busy  <= 1'b1;
                bitn  <= 0;
                div   <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic uart_byte(input string tag, input logic [7:0] exp);
        int n;
        logic [9:0] got;
        n = 0;
        while (line !== 1'b0 && n < 200) begin
            step();
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < 200), 32'd1);
        repeat (2) step();
        for (int k = 0; k < 10; k++) begin
            got[k] = line;
            if (k < 9) repeat (WAIT_DIV) step();
        end
        check({tag, "_startbit"}, 32'(got[0]), 32'd0);
        check({tag, "_data"}, 32'(got[8:1]), 32'(exp));
        check({tag, "_stopbit"}, 32'(got[9]), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b1;
        step();

        // Single byte, 1-cycle latency, held while not ready
        push(8'h41);
        check("one_tvalid", 32'(tvalid), 32'd1);
        check("one_tdata", 32'(tdata), 32'h41);
        check("one_count", 32'(count), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_tdata", 32'(tdata), 32'h41);
            check("hold_tvalid", 32'(tvalid), 32'd1);
        end
        tready_drv = 1'b1;
        step();
        tready_drv = 1'b0;
        check("one_drained", 32'(count), 32'd0);

        // Fill to full, dropped write, push+pop while full
        for (int i = 1; i <= DEPTH; i++) push(8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        push(8'hEE);
        check("drop_count", 32'(count), 32'd16);
        check("drop_tdata", 32'(tdata), 32'h01);
        tready_drv = 1'b1;
        push(8'hAA);
        tready_drv = 1'b0;
        check("pp_full_count", 32'(count), 32'd15);
        check("pp_full_notfull", 32'(full), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        check("ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
`else
        check("ovf_off", 32'(overflow), 32'd0);
`endif
        tready_drv = 1'b1;
        for (int i = 2; i <= DEPTH; i++) begin
            check("drain_tdata", 32'(tdata), 32'(i));
            step();
        end
        tready_drv = 1'b0;
        check("drain_tvalid", 32'(tvalid), 32'd0);
        check("drain_count", 32'(count), 32'd0);

        // Streaming at occupancy 5 across pointer wrap
        for (int i = 0; i < 5; i++) begin
            push(8'(8'h80 + i));
            exp_q.push_back(8'(8'h80 + i));
        end
        tready_drv = 1'b1;
        wr_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr_data = 8'(8'h85 + i);
            check("stream_tdata", 32'(tdata), 32'(exp_q.pop_front()));
            exp_q.push_back(wr_data);
            step();
            check("stream_count", 32'(count), 32'd5);
        end
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stream_tail", 32'(tdata), 32'(exp_q.pop_front()));
            step();
        end
        tready_drv = 1'b0;
        check("stream_empty", 32'(tvalid), 32'd0);

        // Asynchronous reset with 7 queued bytes mid-handshake
        for (int i = 0; i < 7; i++) push(8'(8'h30 + i));
        check("pre_rst_count", 32'(count), 32'd7);
        tready_drv = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("arst_tvalid", 32'(tvalid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_full", 32'(full), 32'd0);
        step();
        tready_drv = 1'b0;
        rst = 1'b1;
        step();
        push(8'h55);
        check("post_rst_tdata", 32'(tdata), 32'h55);
        check("post_rst_count", 32'(count), 32'd1);
        tready_drv = 1'b1;
        step();
        tready_drv = 1'b0;
        check("post_rst_empty", 32'(tvalid), 32'd0);

        // Serial transmission of "Hi"
        uart_on = 1'b1;
        push(8'h48);
        push(8'h69);
        uart_byte("uart_H", 8'h48);
        uart_byte("uart_i", 8'h69);
        repeat (WAIT_DIV * 2) step();
        check("uart_done", 32'(tvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
